sysid_boot_checker: RTL and testbench

//  Avalon-MM read master that sequences the system-ID slave after reset or on request.

---
 rtl/sysid_pkg.sv | 29 ++
 rtl/sysid_boot_checker_if.sv | 15 +
 rtl/avm_read_timer.sv | 43 ++++
 rtl/sysid_boot_checker.sv | 186 ++++++++++++++++++
 tb/tb_sysid_boot_checker.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sysid_pkg.sv
// Shared definitions for the system-ID boot checker: FSM states, sysid word
// addresses, the default build-time words and the pass/fail compare.
package sysid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_ID  = 3'd1,
    ST_LAT_ID = 3'd2,
    ST_RD_TS  = 3'd3,
    ST_LAT_TS = 3'd4,
    ST_FINISH = 3'd5
  } sysid_state_e;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] SYSID_DEFAULT_ID = 32'hACD51302;
  localparam logic [31:0] SYSID_DEFAULT_TS = 32'h558A0D5F;

  // A check passes when the ID matches and, if enabled, the timestamp matches.
  function automatic logic sysid_words_ok(input logic [31:0] id_word,
                                          input logic [31:0] ts_word,
                                          input logic [31:0] exp_id,
                                          input logic [31:0] exp_ts,
                                          input logic        check_ts);
    return (id_word == exp_id) && (!check_ts || (ts_word == exp_ts));
  endfunction

endpackage

// File: rtl/sysid_boot_checker_if.sv
// Avalon-MM read-only link between the boot checker (master) and the sysid slave.
// Handshake: the master raises avm_read with a stable avm_address and holds both
// until an edge where avm_waitrequest is low; that edge accepts the read. Read data
// is valid READ_LATENCY cycles after acceptance (on the accepting edge when zero).
interface sysid_boot_checker_if;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (output avm_address, output avm_read,
                  input  avm_waitrequest, input avm_readdata);
  modport slave  (input  avm_address, input avm_read,
                  output avm_waitrequest, output avm_readdata);
endinterface

// File: rtl/avm_read_timer.sv
// Shared per-read counter: measures read latency after acceptance and stall time
// while a read is outstanding. Saturates at TIMEOUT_CYCLES, never wraps.
module avm_read_timer #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int READ_LATENCY   = 0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic lat_tc,
  output logic to_tc
);

  localparam int CW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LAT_LAST_I = (READ_LATENCY > 0) ? READ_LATENCY - 1 : 0;
  localparam logic [CW-1:0] LAT_LAST = CW'(LAT_LAST_I);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] TO_MAX   = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;

  // Clear has priority; otherwise count up while enabled, holding at the top.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != TO_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  // The current cycle is the last latency cycle / the last allowed stall cycle.
  assign lat_tc = (cnt_q == LAT_LAST);
  assign to_tc  = (cnt_q >= TO_LAST);

endmodule

// File: rtl/sysid_boot_checker.sv
// Boot-time system-ID checker: reads the ID and timestamp words from the sysid
// slave, compares them with the build-time values and holds sticky results.
module sysid_boot_checker
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = SYSID_DEFAULT_ID,
  parameter logic [31:0] EXPECTED_TS    = SYSID_DEFAULT_TS,
  parameter bit          CHECK_TS       = 1'b1,
  parameter int          READ_LATENCY   = 0,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  sysid_boot_checker_if.master   avm,
  output logic [31:0]            id_value,
  output logic [31:0]            ts_value,
  output logic                   busy,
  output logic                   done,
  output logic                   id_ok,
  output logic                   timeout_err,
  output sysid_state_e           dbg_state
);

  sysid_state_e state_q, state_d;
  logic         auto_q, auto_d;
  logic [31:0]  id_value_q, id_value_d;
  logic [31:0]  ts_value_q, ts_value_d;
  logic         id_ok_q, id_ok_d;
  logic         to_err_q, to_err_d;

  logic timer_clr, timer_en, lat_tc, to_tc;
  logic start_chk, cap_id, cap_ts, to_hit;

  avm_read_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .READ_LATENCY   (READ_LATENCY)
  ) u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (timer_clr),
    .en      (timer_en),
    .lat_tc  (lat_tc),
    .to_tc   (to_tc)
  );

  // State and result registers; auto_q arms the one-shot check after reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      auto_q     <= AUTO_START;
      id_value_q <= '0;
      ts_value_q <= '0;
      id_ok_q    <= 1'b0;
      to_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      auto_q     <= auto_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
      id_ok_q    <= id_ok_d;
      to_err_q   <= to_err_d;
    end
  end

  // Next state plus the capture/timeout events that drive the datapath.
  // Acceptance wins over timeout on the same edge.
  always_comb begin
    state_d   = state_q;
    timer_clr = 1'b0;
    timer_en  = 1'b0;
    start_chk = 1'b0;
    cap_id    = 1'b0;
    cap_ts    = 1'b0;
    to_hit    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start || auto_q) begin
          state_d   = ST_RD_ID;
          timer_clr = 1'b1;
          start_chk = 1'b1;
        end
      end
      ST_RD_ID: begin
        if (!avm.avm_waitrequest) begin
          timer_clr = 1'b1;
          if (READ_LATENCY == 0) begin
            cap_id  = 1'b1;
            state_d = ST_RD_TS;
          end else begin
            state_d = ST_LAT_ID;
          end
        end else if (to_tc) begin
          to_hit  = 1'b1;
          state_d = ST_FINISH;
        end else begin
          timer_en = 1'b1;
        end
      end
      ST_LAT_ID: begin
        if (lat_tc) begin
          cap_id    = 1'b1;
          timer_clr = 1'b1;
          state_d   = ST_RD_TS;
        end else if (to_tc) begin
          to_hit  = 1'b1;
          state_d = ST_FINISH;
        end else begin
          timer_en = 1'b1;
        end
      end
      ST_RD_TS: begin
        if (!avm.avm_waitrequest) begin
          timer_clr = 1'b1;
          if (READ_LATENCY == 0) begin
            cap_ts  = 1'b1;
            state_d = ST_FINISH;
          end else begin
            state_d = ST_LAT_TS;
          end
        end else if (to_tc) begin
          to_hit  = 1'b1;
          state_d = ST_FINISH;
        end else begin
          timer_en = 1'b1;
        end
      end
      ST_LAT_TS: begin
        if (lat_tc) begin
          cap_ts  = 1'b1;
          state_d = ST_FINISH;
        end else if (to_tc) begin
          to_hit  = 1'b1;
          state_d = ST_FINISH;
        end else begin
          timer_en = 1'b1;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Result datapath: clear on check start, capture words, decide pass/fail on
  // the edge that enters FINISH so id_ok is valid while done is high.
  always_comb begin
    auto_d     = start_chk ? 1'b0 : auto_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;
    id_ok_d    = id_ok_q;
    to_err_d   = to_err_q;
    if (start_chk) begin
      id_value_d = '0;
      ts_value_d = '0;
      id_ok_d    = 1'b0;
      to_err_d   = 1'b0;
    end
    if (cap_id) id_value_d = avm.avm_readdata;
    if (cap_ts) begin
      ts_value_d = avm.avm_readdata;
      id_ok_d    = sysid_words_ok(id_value_q, avm.avm_readdata,
                                  EXPECTED_ID, EXPECTED_TS, CHECK_TS);
    end
    if (to_hit) begin
      to_err_d = 1'b1;
      id_ok_d  = 1'b0;
    end
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    avm.avm_read    = (state_q == ST_RD_ID) || (state_q == ST_RD_TS);
    avm.avm_address = (state_q == ST_RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
    busy            = (state_q == ST_RD_ID) || (state_q == ST_LAT_ID) ||
                      (state_q == ST_RD_TS) || (state_q == ST_LAT_TS);
    done            = (state_q == ST_FINISH);
    dbg_state       = state_q;
  end

  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;
  assign id_ok       = id_ok_q;
  assign timeout_err = to_err_q;

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Directed bench for sysid_boot_checker. Instance A uses the defaults
// (zero latency, auto start); instance B has CHECK_TS=0, READ_LATENCY=2,
// TIMEOUT_CYCLES=16 and no auto start. Inputs change on the falling edge,
// outputs are checked on the falling edge.
module tb_sysid_boot_checker;
  import sysid_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  // ---------------- instance A ----------------
  logic         start_a = 1'b0;
  logic         wait_a  = 1'b0;
  logic [31:0]  id_word_a = 32'hACD51302;
  logic [31:0]  ts_word_a = 32'h558A0D5F;
  logic [31:0]  id_value_a, ts_value_a;
  logic         busy_a, done_a, id_ok_a, timeout_err_a;
  sysid_state_e dbg_a;
  sysid_boot_checker_if if_a ();

  assign if_a.avm_waitrequest = wait_a;
  assign if_a.avm_readdata = (if_a.avm_read && !wait_a) ?
                             (if_a.avm_address ? ts_word_a : id_word_a) : 32'h0BAD0BAD;

  sysid_boot_checker u_a (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start_a),
    .avm         (if_a),
    .id_value    (id_value_a),
    .ts_value    (ts_value_a),
    .busy        (busy_a),
    .done        (done_a),
    .id_ok       (id_ok_a),
    .timeout_err (timeout_err_a),
    .dbg_state   (dbg_a)
  );

  // ---------------- instance B ----------------
  logic         start_b = 1'b0;
  logic         wait_b  = 1'b0;
  logic [31:0]  id_word_b = 32'hACD51302;
  logic [31:0]  ts_word_b = 32'h558A0D5F;
  logic [31:0]  id_value_b, ts_value_b;
  logic         busy_b, done_b, id_ok_b, timeout_err_b;
  sysid_state_e dbg_b;
  sysid_boot_checker_if if_b ();
  logic [1:0]   v_b, a_b;

  assign if_b.avm_waitrequest = wait_b;
  assign if_b.avm_readdata = v_b[1] ? (a_b[1] ? ts_word_b : id_word_b) : 32'h0BAD0BAD;

  sysid_boot_checker #(
    .CHECK_TS       (1'b0),
    .READ_LATENCY   (2),
    .TIMEOUT_CYCLES (16),
    .AUTO_START     (1'b0)
  ) u_b (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start_b),
    .avm         (if_b),
    .id_value    (id_value_b),
    .ts_value    (ts_value_b),
    .busy        (busy_b),
    .done        (done_b),
    .id_ok       (id_ok_b),
    .timeout_err (timeout_err_b),
    .dbg_state   (dbg_b)
  );

  // Latency-2 slave model for B: data valid two cycles after acceptance.
  logic prev_stall_b, prev_read_b, prev_addr_b;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v_b <= '0;
      a_b <= '0;
      prev_stall_b <= 1'b0;
      prev_read_b  <= 1'b0;
      prev_addr_b  <= 1'b0;
    end else begin
      v_b <= {v_b[0], if_b.avm_read & ~if_b.avm_waitrequest};
      a_b <= {a_b[0], if_b.avm_address};
      prev_stall_b <= if_b.avm_read & if_b.avm_waitrequest;
      prev_read_b  <= if_b.avm_read;
      prev_addr_b  <= if_b.avm_address;
    end
  end

  // Bus monitors: accepted reads on A, timestamp requests and stall stability on B.
  int acc_a = 0;
  int ts_req_b = 0;
  int unstable_b = 0;
  always @(posedge clock) begin
    if (if_a.avm_read && !if_a.avm_waitrequest) acc_a++;
    if (if_b.avm_read && if_b.avm_address) ts_req_b++;
    if (reset_n && prev_stall_b &&
        ((if_b.avm_read !== prev_read_b) || (if_b.avm_address !== prev_addr_b)))
      unstable_b++;
  end

  // ---------------- scoreboard ----------------
  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_start_a();
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
  endtask

  task automatic pulse_start_b();
    start_b = 1'b1;
    @(negedge clock);
    start_b = 1'b0;
  endtask

  task automatic wait_done_a(input int max, output int n);
    n = 0;
    while (done_a !== 1'b1 && n < max) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic wait_done_b(input int max, output int n);
    n = 0;
    while (done_b !== 1'b1 && n < max) begin
      @(negedge clock);
      n++;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int base;

    // Reset values.
    repeat (3) @(negedge clock);
    chk1("rst_busy", busy_a, 1'b0);
    chk1("rst_done", done_a, 1'b0);
    chk1("rst_id_ok", id_ok_a, 1'b0);
    chk1("rst_timeout", timeout_err_a, 1'b0);
    chk1("rst_read", if_a.avm_read, 1'b0);
    chk("rst_id_value", id_value_a, 32'h0);
    chk1("rst_state_idle", dbg_a == ST_IDLE, 1'b1);

    // Auto start after release, with a coincident start pulse: one check only.
    reset_n = 1'b1;
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    chk1("t1_read_id", if_a.avm_read, 1'b1);
    chk1("t1_addr_id", if_a.avm_address, 1'b0);
    chk1("t1_busy", busy_a, 1'b1);
    @(negedge clock);
    chk1("t1_read_ts", if_a.avm_read, 1'b1);
    chk1("t1_addr_ts", if_a.avm_address, 1'b1);
    @(negedge clock);
    chk1("t1_done", done_a, 1'b1);
    chk1("t1_busy_fin", busy_a, 1'b0);
    chk1("t1_id_ok", id_ok_a, 1'b1);
    chk("t1_id_value", id_value_a, 32'hACD51302);
    chk("t1_ts_value", ts_value_a, 32'h558A0D5F);
    @(negedge clock);
    chk1("t1_done_pulse", done_a, 1'b0);
    chk1("t1_id_ok_sticky", id_ok_a, 1'b1);
    repeat (3) @(negedge clock);
    chk1("t1_single_check", busy_a, 1'b0);
    chk("t1_reads", acc_a, 2);
    chk1("t1_b_no_auto", dbg_b == ST_IDLE, 1'b1);

    // Wrong ID; start pulses while busy and in FINISH are ignored.
    id_word_a = 32'hDEADBEEF;
    base = acc_a;
    pulse_start_a();
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    wait_done_a(10, n);
    chk("t2_done_latency", n, 1);
    chk1("t2_id_ok", id_ok_a, 1'b0);
    chk1("t2_timeout", timeout_err_a, 1'b0);
    chk("t2_id_value", id_value_a, 32'hDEADBEEF);
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    chk1("t2_finish_start_ignored", busy_a, 1'b0);
    @(negedge clock);
    chk1("t2_still_idle", busy_a, 1'b0);
    chk("t2_reads", acc_a - base, 2);

    // Wrong timestamp: fails with CHECK_TS=1 (A), passes with CHECK_TS=0 (B).
    id_word_a = 32'hACD51302;
    ts_word_a = 32'h12345678;
    pulse_start_a();
    wait_done_a(10, n);
    chk("t3a_done_latency", n, 2);
    chk1("t3a_id_ok", id_ok_a, 1'b0);
    chk("t3a_ts_value", ts_value_a, 32'h12345678);
    ts_word_b = 32'h12345678;
    pulse_start_b();
    wait_done_b(20, n);
    chk("t3b_done_latency", n, 6);
    chk1("t3b_id_ok", id_ok_b, 1'b1);
    chk("t3b_ts_value", ts_value_b, 32'h12345678);
    @(negedge clock);

    // Five stall cycles on the ID read, latency 2.
    ts_word_b = 32'h558A0D5F;
    wait_b = 1'b1;
    pulse_start_b();
    for (int i = 0; i < 5; i++) begin
      chk1("t4_stall_read", if_b.avm_read, 1'b1);
      chk1("t4_stall_addr", if_b.avm_address, 1'b0);
      @(negedge clock);
    end
    wait_b = 1'b0;
    @(negedge clock);
    chk1("t4_lat_no_read", if_b.avm_read, 1'b0);
    chk("t4_not_yet_1", id_value_b, 32'h0);
    @(negedge clock);
    chk("t4_not_yet_2", id_value_b, 32'h0);
    @(negedge clock);
    chk("t4_captured", id_value_b, 32'hACD51302);
    wait_done_b(20, n);
    chk("t4_done_latency", n, 3);
    chk1("t4_id_ok", id_ok_b, 1'b1);
    chk("t4_unstable", unstable_b, 0);
    @(negedge clock);

    // Waitrequest stuck high: timeout after 16 stall cycles, no timestamp read.
    base = ts_req_b;
    wait_b = 1'b1;
    pulse_start_b();
    wait_done_b(40, n);
    chk("t5_timeout_latency", n, 16);
    chk1("t5_done", done_b, 1'b1);
    chk1("t5_timeout_err", timeout_err_b, 1'b1);
    chk1("t5_id_ok", id_ok_b, 1'b0);
    chk("t5_no_ts_read", ts_req_b - base, 0);
    wait_b = 1'b0;
    @(negedge clock);

    // Reset mid-read aborts; auto start re-arms on A only.
    ts_word_a = 32'h558A0D5F;
    wait_a = 1'b1;
    pulse_start_a();
    @(negedge clock);
    chk1("t6_busy_before", busy_a, 1'b1);
    reset_n = 1'b0;
    #1;
    chk1("t6_rst_busy", busy_a, 1'b0);
    chk1("t6_rst_read", if_a.avm_read, 1'b0);
    chk1("t6_rst_b_timeout", timeout_err_b, 1'b0);
    chk1("t6_rst_state", dbg_a == ST_IDLE, 1'b1);
    @(negedge clock);
    wait_a = 1'b0;
    reset_n = 1'b1;
    wait_done_a(10, n);
    chk("t6_auto_latency", n, 3);
    chk1("t6_id_ok", id_ok_a, 1'b1);
    chk1("t6_b_idle", busy_b, 1'b0);
    @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global time bound.
  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1);
  end

endmodule
